// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
//
// SPI master that runs one frame per request: a CMD_W-bit command followed by
// a DATA_W-bit data word, MSB first. Supports all four CPOL/CPHA modes, a
// runtime SCLK half-period divider and NUM_CS active-low chip selects.
//
// Ports
//   clk, rst_n     system clock (rising edge), synchronous active-low reset
//   start_tx       request; accepted only in IDLE (spi_busy=0)
//   cmd_in         command word
//   data_in        write data (ignored on read frames)
//   rd_in          1 = read frame, 0 = write frame
//   cs_sel         target chip-select index; >= NUM_CS is rejected (req_err)
//   cpol, cpha     SPI mode for the frame
//   clk_div        half-period H = max(clk_div,1)+1 clk cycles
//   spi_busy       frame in progress (SETUP/SHIFT/HOLD)
//   tx_done        one-cycle completion pulse
//   req_err        one-cycle pulse, request rejected
//   data_read_out  last read word
//   sclk_out, mosi_out, miso_in, cs_n_out   SPI bus
// -----------------------------------------------------------------------------
module spi_master_multi #(
  parameter int CMD_W  = 16,
  parameter int DATA_W = 16,
  parameter int NUM_CS = 8,
  parameter int DIV_W  = 16,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_tx,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_in,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              spi_busy,
  output logic              tx_done,
  output logic              req_err,
  output logic [DATA_W-1:0] data_read_out,
  output logic              sclk_out,
  output logic              mosi_out,
  input  logic              miso_in,
  output logic [NUM_CS-1:0] cs_n_out
);

  localparam int N  = CMD_W + DATA_W;
  localparam int EW = $clog2(2 * N);
  localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * N - 1);
  localparam logic [EW-1:0]  EDGE_ONE  = EW'(1);
  localparam logic [DIV_W:0] CNT_ONE   = (DIV_W + 1)'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state;
  logic [DIV_W:0]    cnt;       // cycles spent in the current half-period
  logic [DIV_W-1:0]  hm1;       // latched H-1 = max(clk_div,1)
  logic [EW-1:0]     edge_idx;  // SCLK edges already issued in SHIFT
  logic [N-1:0]      tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              cpha_q;
  logic              rd_q;

  logic              cs_bad;
  logic              half_up;
  logic              hold_up;
  logic              leading;
  logic              sample_edge;

  always_comb begin
    cs_bad      = ({1'b0, cs_sel} >= (CS_W + 1)'(NUM_CS));
    half_up     = (cnt == {1'b0, hm1});
    // HOLD runs one cycle past H so that DONE lands at H*(2N+2)+1.
    hold_up     = (cnt == ({1'b0, hm1} + CNT_ONE));
    leading     = ~edge_idx[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    sample_edge = leading ^ cpha_q;
  end

  assign spi_busy = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign tx_done  = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: shift registers are reset too; nothing of an aborted frame
      // may surface later, and the cost is negligible at this size.
      state         <= IDLE;
      cnt           <= '0;
      hm1           <= '0;
      edge_idx      <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      cpha_q        <= 1'b0;
      rd_q          <= 1'b0;
      req_err       <= 1'b0;
      data_read_out <= '0;
      sclk_out      <= 1'b0;
      mosi_out      <= 1'b0;
      cs_n_out      <= '1;
    end else begin
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_tx) begin
            if (cs_bad) begin
              req_err <= 1'b1;
            end else begin
              state    <= SETUP;
              cnt      <= '0;
              edge_idx <= '0;
              hm1      <= (clk_div == '0) ? DIV_W'(1) : clk_div;
              tx_sr    <= {cmd_in, rd_in ? DATA_W'(0) : data_in};
              mosi_out <= cmd_in[CMD_W-1];
              cpha_q   <= cpha;
              rd_q     <= rd_in;
              sclk_out <= cpol;
              cs_n_out <= ~(NUM_CS'(1) << cs_sel);
            end
          end
        end

        SETUP: begin
          if (half_up) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        SHIFT: begin
          if (half_up) begin
            cnt      <= '0;
            sclk_out <= ~sclk_out;
            edge_idx <= edge_idx + EDGE_ONE;
            if (sample_edge) begin
              // Command-phase samples fall off the top; only the last
              // DATA_W samples (the data phase) remain at the end.
              rx_sr <= (rx_sr << 1) | DATA_W'(miso_in);
            end else if (!(cpha_q == 1'b0 && edge_idx == LAST_EDGE) &&
                         !(cpha_q == 1'b1 && edge_idx == '0)) begin
              tx_sr    <= tx_sr << 1;
              mosi_out <= tx_sr[N-2];
            end
            if (edge_idx == LAST_EDGE) begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HOLD: begin
          if (hold_up) begin
            cnt      <= '0;
            state    <= DONE;
            cs_n_out <= '1;
            if (rd_q) begin
              data_read_out <= rx_sr;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          cs_n_out <= '1;
        end
      endcase
    end
  end

endmodule
